// File: rtl/pacc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pacc_pkg : shared types, default widths and saturation limits            |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package pacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pacc_state_e;

  localparam int PACC_PROD_W    = 32;
  localparam int PACC_ACC_W     = 40;
  localparam int PACC_BURST_MAX = 16;

  // Limits are returned 64 bits wide; callers truncate to their own width.
  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    sat_min = ~sat_max(w);
  endfunction

endpackage : pacc_pkg
`default_nettype wire

// File: rtl/pacc_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pacc_sat_add : ACC_W signed adder with overflow flag; clamps to the      |
// |                signed limits when PACC_SATURATE_EN is defined            |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module pacc_sat_add
  import pacc_pkg::*;
#(
  parameter int ACC_W = PACC_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_sum;

  assign raw_sum = a + b;
  assign ovf     = (a[ACC_W-1] == b[ACC_W-1]) && (raw_sum[ACC_W-1] != a[ACC_W-1]);

`ifdef PACC_SATURATE_EN
  localparam logic [ACC_W-1:0] C_SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] C_SAT_MIN = ACC_W'(sat_min(ACC_W));

  // On overflow both operands share a sign, which gives the clamp direction.
  always_comb begin
    sum = raw_sum;
    if (ovf) begin
      sum = a[ACC_W-1] ? C_SAT_MIN : C_SAT_MAX;
    end
  end
`else
  assign sum = raw_sum;
`endif

endmodule : pacc_sat_add
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | product_accumulator : sums bursts of signed products into a wide         |
// |                       accumulator and hands the result downstream        |
// | Config macro        : PACC_SATURATE_EN (clamp instead of wrap)           |
// | Rev 1.0             : initial release                                    |
// +--------------------------------------------------------------------------+
module product_accumulator
  import pacc_pkg::*;
#(
  parameter  int PROD_W    = PACC_PROD_W,
  parameter  int ACC_W     = PACC_ACC_W,
  parameter  int BURST_MAX = PACC_BURST_MAX,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready_o,
  input  logic              acc_clear,
  output logic [ACC_W-1:0]  res_o,
  output logic [CNT_W-1:0]  res_count_o,
  output logic              overflow_o,
  output logic              res_valid_o,
  input  logic              res_ready
);

  localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(BURST_MAX);

  pacc_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] count_inc;
  logic             handshake;
  logic             closing;

  assign prod_ext     = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign prod_ready_o = (state_q != HOLD) && !acc_clear;
  assign handshake    = prod_valid && prod_ready_o;
  assign count_inc    = count_q + CNT_W'(1);
  assign closing      = prod_last || (count_inc == C_BURST_MAX);

  pacc_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;

    // Clear wins in every state; a concurrent res_ready in HOLD still consumes the result.
    if (acc_clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (handshake) begin
            acc_d   = add_sum;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
            state_d = ACCUM;
            if (closing) begin
              state_d     = HOLD;
              res_d       = add_sum;
              res_count_d = count_inc;
              res_ovf_d   = ovf_q | add_ovf;
              res_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_valid_q && res_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_o       = res_q;
  assign res_count_o = res_count_q;
  assign overflow_o  = res_ovf_q;
  assign res_valid_o = res_valid_q;

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_product_accumulator : directed self-checking bench, ACC_W=33 build    |
// | Rev 1.0                : initial release                                 |
// +--------------------------------------------------------------------------+
module tb_product_accumulator;

  localparam int PROD_W    = 32;
  localparam int ACC_W     = 33;
  localparam int BURST_MAX = 16;
  localparam int CNT_W     = $clog2(BURST_MAX + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready_o;
  logic              acc_clear;
  logic [ACC_W-1:0]  res_o;
  logic [CNT_W-1:0]  res_count_o;
  logic              overflow_o;
  logic              res_valid_o;
  logic              res_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  product_accumulator #(
    .PROD_W    (PROD_W),
    .ACC_W     (ACC_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prod         (prod),
    .prod_valid   (prod_valid),
    .prod_last    (prod_last),
    .prod_ready_o (prod_ready_o),
    .acc_clear    (acc_clear),
    .res_o        (res_o),
    .res_count_o  (res_count_o),
    .overflow_o   (overflow_o),
    .res_valid_o  (res_valid_o),
    .res_ready    (res_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input longint val, input logic last);
    prod       = PROD_W'(val);
    prod_valid = 1'b1;
    prod_last  = last;
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  longint exp_ovf_res;

  initial begin
    rst_n      = 1'b0;
    prod       = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    acc_clear  = 1'b0;
    res_ready  = 1'b0;
    tick();
    tick();
    chk("rst_valid", longint'(res_valid_o), 0);
    chk("rst_res", longint'($signed(res_o)), 0);
    chk("rst_ovf", longint'(overflow_o), 0);
    chk("rst_count", longint'(res_count_o), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", longint'(prod_ready_o), 1);

    // Burst 100, -30, 7
    send(100, 1'b0);
    send(-30, 1'b0);
    chk("b1_not_yet", longint'(res_valid_o), 0);
    send(7, 1'b1);
    chk("b1_valid", longint'(res_valid_o), 1);
    chk("b1_res", longint'($signed(res_o)), 77);
    chk("b1_count", longint'(res_count_o), 3);
    chk("b1_ovf", longint'(overflow_o), 0);
    chk("b1_ready_hold", longint'(prod_ready_o), 0);
    prod       = 32'd1000;
    prod_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    prod_valid = 1'b0;
    chk("b1_hold_valid", longint'(res_valid_o), 1);
    chk("b1_hold_res", longint'($signed(res_o)), 77);
    chk("b1_hold_count", longint'(res_count_o), 3);
    chk("b1_hold_ready", longint'(prod_ready_o), 0);
    consume();
    chk("b1_drop_valid", longint'(res_valid_o), 0);
    chk("b1_ready_back", longint'(prod_ready_o), 1);

    // Sixteen ones with no last flag close on the term count
    for (int i = 0; i < 15; i++) send(1, 1'b0);
    chk("auto_not_yet", longint'(res_valid_o), 0);
    send(1, 1'b0);
    chk("auto_valid", longint'(res_valid_o), 1);
    chk("auto_res", longint'($signed(res_o)), 16);
    chk("auto_count", longint'(res_count_o), 16);
    consume();

    // Three max-positive products overflow a 33-bit accumulator
`ifdef PACC_SATURATE_EN
    exp_ovf_res = 64'sd4294967295;
`else
    exp_ovf_res = -64'sd2147483651;
`endif
    send(64'h7FFF_FFFF, 1'b0);
    send(64'h7FFF_FFFF, 1'b0);
    send(64'h7FFF_FFFF, 1'b1);
    chk("ovf_valid", longint'(res_valid_o), 1);
    chk("ovf_res", longint'($signed(res_o)), exp_ovf_res);
    chk("ovf_flag", longint'(overflow_o), 1);
    chk("ovf_count", longint'(res_count_o), 3);
    consume();

    // Abort mid-burst; the offered term in the clear cycle must be refused
    send(9, 1'b0);
    send(9, 1'b0);
    acc_clear  = 1'b1;
    prod       = 32'd100;
    prod_valid = 1'b1;
    #1;
    chk("clr_ready_low", longint'(prod_ready_o), 0);
    tick();
    acc_clear  = 1'b0;
    prod_valid = 1'b0;
    chk("clr_no_valid", longint'(res_valid_o), 0);
    send(5, 1'b1);
    chk("clr_res", longint'($signed(res_o)), 5);
    chk("clr_count", longint'(res_count_o), 1);
    chk("clr_ovf", longint'(overflow_o), 0);

    // Clear and ready together in HOLD: a single transfer, then a fresh burst
    acc_clear = 1'b1;
    res_ready = 1'b1;
    tick();
    acc_clear = 1'b0;
    chk("cr_valid_drop", longint'(res_valid_o), 0);
    tick();
    res_ready = 1'b0;
    chk("cr_still_low", longint'(res_valid_o), 0);
    chk("cr_ready", longint'(prod_ready_o), 1);
    send(-5, 1'b1);
    chk("cr_next_valid", longint'(res_valid_o), 1);
    chk("cr_next_res", longint'($signed(res_o)), -5);
    chk("cr_next_count", longint'(res_count_o), 1);

    // Reset while holding discards the result
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_hold_valid", longint'(res_valid_o), 0);
    chk("rst_hold_res", longint'($signed(res_o)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_product_accumulator
`default_nettype wire
